// File: rtl/rs_operand_collector_pkg.sv
// rs_operand_collector_pkg: shared widths and operand-slot type for the RS operand collector
package rs_operand_collector_pkg;
    localparam int RS_DEPTH = 4;
    localparam int PRF_SIZE = 16;
    localparam int TAG_W    = 4;
    localparam int DATA_W   = 8;
    localparam int OP_W     = 4;
    localparam int SLOTS    = 2 * RS_DEPTH;
    localparam int ENT_W    = $clog2(RS_DEPTH);
    localparam int SLOT_W   = $clog2(SLOTS);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              have;
        logic [DATA_W-1:0] val;
    } operand_t;
endpackage

// File: rtl/rs_operand_collector_if.sv
// rs_operand_collector_if: dispatch, PRF request/CDB and issue signals of the operand collector
interface rs_operand_collector_if;
    import rs_operand_collector_pkg::*;
    logic                disp_valid;
    logic                disp_ready;
    logic [OP_W-1:0]     disp_op;
    logic [TAG_W-1:0]    disp_src1_tag;
    logic [TAG_W-1:0]    disp_src2_tag;
    logic [TAG_W-1:0]    disp_dst_tag;
    logic [PRF_SIZE-1:0] ready_regs;
    logic                req_valid;
    logic [TAG_W-1:0]    req_id;
    logic                cdb_transmit;
    logic [TAG_W-1:0]    cdb_id;
    logic [DATA_W-1:0]   cdb_val;
    logic                iss_valid;
    logic                iss_ready;
    logic [OP_W-1:0]     iss_op;
    logic [DATA_W-1:0]   iss_a;
    logic [DATA_W-1:0]   iss_b;
    logic [TAG_W-1:0]    iss_dst;

    modport slave (
        input  disp_valid, disp_op, disp_src1_tag, disp_src2_tag, disp_dst_tag,
        input  ready_regs, cdb_transmit, cdb_id, cdb_val, iss_ready,
        output disp_ready, req_valid, req_id, iss_valid, iss_op, iss_a, iss_b, iss_dst
    );

    modport master (
        output disp_valid, disp_op, disp_src1_tag, disp_src2_tag, disp_dst_tag,
        output ready_regs, cdb_transmit, cdb_id, cdb_val, iss_ready,
        input  disp_ready, req_valid, req_id, iss_valid, iss_op, iss_a, iss_b, iss_dst
    );
endinterface

// File: rtl/rs_operand_collector_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after ptr, wrapping at N
module rr_arbiter #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         any
);
    // scan N positions starting at ptr; the first requester wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any     = 1'b1;
                gnt_idx = W'((int'(ptr) + i) % N);
            end
        end
        if (any) gnt[gnt_idx] = 1'b1;
    end
endmodule

// File: rtl/rs_operand_collector.sv
// rs_operand_collector: reservation station that gathers operands via PRF requests and CDB snooping
module rs_operand_collector
    import rs_operand_collector_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    rs_operand_collector_if.slave bus
);
    logic [RS_DEPTH-1:0] valid;
    logic [OP_W-1:0]     op  [RS_DEPTH];
    logic [TAG_W-1:0]    dst [RS_DEPTH];
    operand_t            opnd [SLOTS];
    logic [SLOT_W-1:0]   ptr;
    logic [SLOTS-1:0]    elig;
    logic [SLOTS-1:0]    gnt;
    logic [SLOTS-1:0]    hit;
    logic [SLOT_W-1:0]   gnt_idx;
    logic                req_any;
    logic [TAG_W-1:0]    req_tag;
    logic [RS_DEPTH-1:0] rdy;
    logic [ENT_W-1:0]    free_idx;
    logic [ENT_W-1:0]    iss_idx;
    logic                any_free;
    logic                any_rdy;
    logic                disp_fire;
    logic                iss_fire;
    logic                hit1;
    logic                hit2;

    rr_arbiter #(.N(SLOTS)) u_arb (
        .req     (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (req_any)
    );

    // per-slot request eligibility, CDB match, and per-entry issue readiness
    always_comb begin
        elig = '0;
        hit  = '0;
        rdy  = '0;
        for (int s = 0; s < SLOTS; s++) begin
            elig[s] = valid[s/2] && !opnd[s].have && bus.ready_regs[opnd[s].tag];
            hit[s]  = valid[s/2] && !opnd[s].have && bus.cdb_transmit && opnd[s].tag == bus.cdb_id;
        end
        for (int e = 0; e < RS_DEPTH; e++)
            rdy[e] = valid[e] && opnd[2*e].have && opnd[2*e+1].have;
    end

    // tag of the granted slot; zero when nothing is granted
    always_comb begin
        req_tag = '0;
        for (int s = 0; s < SLOTS; s++)
            req_tag |= gnt[s] ? opnd[s].tag : '0;
    end

    // lowest free entry for dispatch and lowest ready entry for issue
    always_comb begin
        free_idx = '0;
        iss_idx  = '0;
        any_free = 1'b0;
        any_rdy  = 1'b0;
        for (int e = RS_DEPTH - 1; e >= 0; e--) begin
            if (!valid[e]) begin
                any_free = 1'b1;
                free_idx = ENT_W'(e);
            end
            if (rdy[e]) begin
                any_rdy = 1'b1;
                iss_idx = ENT_W'(e);
            end
        end
    end

    assign disp_fire = bus.disp_valid && any_free;
    assign iss_fire  = any_rdy && bus.iss_ready;
    assign hit1      = bus.cdb_transmit && bus.cdb_id == bus.disp_src1_tag;
    assign hit2      = bus.cdb_transmit && bus.cdb_id == bus.disp_src2_tag;

    assign bus.disp_ready = any_free;
    assign bus.req_valid  = req_any;
    assign bus.req_id     = req_tag;
    assign bus.iss_valid  = any_rdy;
    assign bus.iss_op     = any_rdy ? op[iss_idx] : '0;
    assign bus.iss_a      = any_rdy ? opnd[{iss_idx, 1'b0}].val : '0;
    assign bus.iss_b      = any_rdy ? opnd[{iss_idx, 1'b1}].val : '0;
    assign bus.iss_dst    = any_rdy ? dst[iss_idx] : '0;

    // entry, operand and pointer state; dispatch only writes a free entry, so it never collides with capture or issue-free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            ptr   <= '0;
            for (int e = 0; e < RS_DEPTH; e++) begin
                op[e]  <= '0;
                dst[e] <= '0;
            end
            for (int s = 0; s < SLOTS; s++)
                opnd[s] <= '0;
        end else begin
            if (req_any)
                ptr <= (gnt_idx == SLOT_W'(SLOTS - 1)) ? '0 : gnt_idx + SLOT_W'(1);
            for (int s = 0; s < SLOTS; s++) begin
                if (hit[s]) begin
                    opnd[s].have <= 1'b1;
                    opnd[s].val  <= bus.cdb_val;
                end
            end
            if (iss_fire)
                valid[iss_idx] <= 1'b0;
            if (disp_fire) begin
                valid[free_idx] <= 1'b1;
                op[free_idx]    <= bus.disp_op;
                dst[free_idx]   <= bus.disp_dst_tag;
                opnd[{free_idx, 1'b0}] <= '{tag: bus.disp_src1_tag, have: hit1,
                                            val: hit1 ? bus.cdb_val : DATA_W'(0)};
                opnd[{free_idx, 1'b1}] <= '{tag: bus.disp_src2_tag, have: hit2,
                                            val: hit2 ? bus.cdb_val : DATA_W'(0)};
            end
        end
    end
endmodule
